// File: rtl/dcpu16_mem_if.sv
// dcpu16_mem_if: core fetch/store port and streaming boot-loader port bundle.
`default_nettype none
`timescale 1ns/1ps

interface dcpu16_mem_if;
  logic [15:0] ram_addr;
  logic [15:0] ram_dout;
  logic        ram_we;
  logic [15:0] ram_din;
  logic        ld_start;
  logic [15:0] ld_base;
  logic [15:0] ld_count;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        cpu_rst_n;

  modport master (
    output ram_addr, ram_we, ram_din,
    output ld_start, ld_base, ld_count, ld_valid, ld_data,
    input  ram_dout, ld_ready, ld_busy, ld_done, cpu_rst_n
  );

  modport slave (
    input  ram_addr, ram_we, ram_din,
    input  ld_start, ld_base, ld_count, ld_valid, ld_data,
    output ram_dout, ld_ready, ld_busy, ld_done, cpu_rst_n
  );
endinterface

`default_nettype wire

// File: rtl/dcpu16_mem.sv
// ============================================================================
// dcpu16_mem : DCPU16 program/data RAM with streaming boot loader that holds
//              the core in reset until an image has been loaded.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dcpu16_mem #(
  parameter int ADDR_W = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  dcpu16_mem_if.slave bus
);

  localparam int c_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_idx;
  logic [15:0] r_base;
  logic [15:0] r_count;
  logic [15:0] r_dout;
  logic [15:0] r_mem [c_DEPTH];

  logic        w_accept;
  logic        w_last;
  logic        w_core_wr;
  logic        w_start;
  logic [15:0] w_ld_sum;
  logic        w_unused_bits;

  // idx==count in LOAD means the image is complete (covers count==0 too),
  // so ld_ready can stay a pure state decode without ever over-accepting.
  assign w_accept  = (r_state == ST_LOAD) && bus.ld_valid && (r_idx != r_count);
  assign w_last    = ((r_idx + 16'd1) == r_count);
  assign w_core_wr = (r_state == ST_DONE) && bus.ram_we;
  assign w_start   = (r_state != ST_LOAD) && bus.ld_start;
  assign w_ld_sum  = r_base + r_idx;

  assign w_unused_bits = ^{bus.ram_addr, w_ld_sum};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.ld_start) w_state_nxt = ST_LOAD;
      ST_LOAD: if ((r_idx == r_count) || (w_accept && w_last)) w_state_nxt = ST_DONE;
      ST_DONE: if (bus.ld_start) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 16'd0;
      r_base  <= 16'd0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_base  <= bus.ld_base;
        r_count <= bus.ld_count;
        r_idx   <= 16'd0;
      end else if (w_accept) begin
        r_idx <= r_idx + 16'd1;
      end
    end
  end

  // Loader and core writes are state-exclusive, so one write port suffices.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[w_ld_sum[ADDR_W-1:0]] <= bus.ld_data;
    end else if (w_core_wr) begin
      r_mem[bus.ram_addr[ADDR_W-1:0]] <= bus.ram_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 16'd0;
    end else begin
      r_dout <= r_mem[bus.ram_addr[ADDR_W-1:0]];
    end
  end

  assign bus.ram_dout  = r_dout;
  assign bus.ld_ready  = (r_state == ST_LOAD);
  assign bus.ld_busy   = (r_state == ST_LOAD);
  assign bus.ld_done   = (r_state == ST_DONE);
  assign bus.cpu_rst_n = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: doc/dcpu16_mem.md
# dcpu16_mem

Word-addressed program/data memory that answers the DCPU16 core's fetch port (`ram_addr` in, `ram_dout` out). It also contains a streaming boot loader that fills memory from an external valid/ready source before the core runs. The block holds the core in reset through its `cpu_rst_n` output until a load completes, so the core always fetches from address 0 of a loaded image.

## Interface
- `ADDR_W`, default 16: memory depth is 2^ADDR_W 16-bit words. Legal range 4..16.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ram_addr`  in  16  core address. Only bits [ADDR_W-1:0] are used.
- `ram_dout`  out  16  read data, registered.
- `ram_we`  in  1  core write enable. Reserved for the core's store path.
- `ram_din`  in  16  core write data.
- `ld_start`  in  1  one-cycle pulse that begins a load.
- `ld_base`  in  16  first load address. Sampled on `ld_start`.
- `ld_count`  in  16  number of words to load. Sampled on `ld_start`.
- `ld_valid`  in  1  loader data valid.
- `ld_data`  in  16  loader data word.
- `ld_ready`  out  1  loader accepts a word.
- `ld_busy`  out  1  load in progress.
- `ld_done`  out  1  the last load has completed.
- `cpu_rst_n`  out  1  active-low reset to the core.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE→LOAD on `ld_start`.
  - LOAD→DONE when the accepted word count reaches `ld_count`.
  - DONE→LOAD on `ld_start` (reload).
  - `ld_start` in LOAD is ignored.
- LOAD with `ld_count`=0 goes to DONE on the next edge. No words are accepted.
- Loader handshake:
  - `ld_ready` = (state==LOAD).
  - A word transfers on any edge where `ld_valid && ld_ready`.
  - It is written to address (`base_reg` + `idx`) mod 2^ADDR_W, then `idx` increments.
  - Address wrap past the top of memory is legal and silent.
  - `ld_data` is don't-care when `ld_valid`=0. The source may drop `ld_valid` at any time.
- Core port:
  - Reads are serviced in every state.
  - `ram_dout` <= mem[`ram_addr`[ADDR_W-1:0]] every edge.
  - Core writes (`ram_we`) are performed only in DONE and are ignored in IDLE and LOAD.
  - LOAD never sees a core write, so the two ports never collide.
- Read-during-write to the same address returns the old data (read-first).
- Outputs:
  - `cpu_rst_n` = 1 only in DONE. It drops to 0 on the edge entering LOAD for a reload.
  - `ld_busy` = (state==LOAD).
  - `ld_done` = (state==DONE).
- Reset values:
  - State = IDLE, `idx`=0, `base_reg`=0, `count_reg`=0.
  - `ram_dout`=0, `ld_ready`=0, `ld_busy`=0, `ld_done`=0, `cpu_rst_n`=0.
  - Memory array contents are not reset and keep their values.
- Reset asserted mid-load returns the block to IDLE immediately. Words already written stay in memory; the load is not resumed.

## Timing
- `ld_start` sampled at edge N: state is LOAD and `ld_ready`=1 from cycle N+1.
- The k-th accepted word is written at its handshake edge. It is readable on `ram_dout` one edge after a later read of that address is presented.
- Last word accepted at edge M: state is DONE from cycle M+1.
  - `ld_ready`=0, `ld_done`=1 and `cpu_rst_n`=1 all change together at that edge.
  - No extra word is accepted at M+1.
- Maximum loader throughput is one word per cycle.
- Read latency is 1 cycle: address presented before edge N, data valid after edge N.
- Core write at edge N is visible to a read issued at edge N+1.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Test plan
- **Basic load.** Reset, then `ld_start` with base=0, count=4, then stream 0x7C01, 0x0030, 0x7DE1, 0x1000 with `ld_valid` held high.
  - Required: `ld_ready` high for exactly 4 cycles.
  - Required: `cpu_rst_n` rises the cycle after the 4th word.
  - Required: reads of addresses 0..3 return those words with 1-cycle latency.
- **Throttled source.** `ld_valid` toggles 1,0,0,1,… with count=3.
  - Required: exactly 3 writes at the handshake edges only; `idx`=3 at DONE.
  - Required: the words shown on `ld_data` while `ld_valid`=0 are never written.
- **Wrap and zero count.** ADDR_W=4, base=0xE, count=3, data A,B,C.
  - Required: mem[0xE]=A, mem[0xF]=B, mem[0x0]=C.
  - Then `ld_start` with count=0. Required: LOAD for one cycle, back in DONE, `cpu_rst_n` low for exactly that one cycle.
- **Core writes gated by state.**
  - In DONE, write 0xBEEF to 0x10. Required: a read of 0x10 on the next cycle returns 0xBEEF.
  - Pulse `ld_start` with count=0 and drive `ram_we` during the single LOAD cycle. Required: that write has no effect on memory.
  - Read-first check: read and write 0x10 in the same cycle. Required: the read returns 0xBEEF and the new value appears one cycle later.
- **Reset mid-load.** count=8, assert `rst_n`=0 after 3 words.
  - Required: immediate IDLE, `ld_ready`=0, `cpu_rst_n`=0.
  - Required: words 0..2 remain readable.
  - Required: `ld_start` ignored while in LOAD; a new `ld_start` after reset restarts from `idx`=0.
